// File: rtl/param_scan_mux_pkg.sv
// Shared types and helpers for the parametrised scan multiplexer.
// Build option: define SCAN_ACTIVE_LOW_EN to make ch_en active-low.
`timescale 1ns/1ps
package scan_mux_pkg;

  // Selection mode as presented on the mode input.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } scan_mode_e;

  // Widest one-hot vector the helper can build; N_CH must not exceed this.
  localparam int ONEHOT_MAXW = 64;

  // One-hot code for idx; all zero when idx is outside 0..n-1.
  function automatic logic [ONEHOT_MAXW-1:0] onehot(input int idx, input int n);
    logic [ONEHOT_MAXW-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < ONEHOT_MAXW) begin
      v = ONEHOT_MAXW'(1) << idx;
    end
    return v;
  endfunction

  // Counter width for values 0..v-1; at least one bit so DIV=1 still builds.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/param_scan_mux_if.sv
// Channel data, control and output bundle of param_scan_mux.
// Build option: SCAN_ACTIVE_LOW_EN only changes the ch_en polarity.
`timescale 1ns/1ps
interface param_scan_mux_if #(
  parameter int N_CH = 4,
  parameter int W    = 4
);
  localparam int SELW = $clog2(N_CH);

  logic [N_CH*W-1:0] d;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic              hold;
  logic [W-1:0]      y;
  logic [SELW-1:0]   ch;
  logic [N_CH-1:0]   ch_en;
  logic              tick;

  modport master (
    output d, mode, sel, hold,
    input  y, ch, ch_en, tick
  );

  modport slave (
    input  d, mode, sel, hold,
    output y, ch, ch_en, tick
  );

endinterface

// File: rtl/param_scan_mux_tick_gen.sv
// Auto-scan prescaler: counts 0..DIV-1 while enabled and flags the wrap.
// Not affected by SCAN_ACTIVE_LOW_EN.
`timescale 1ns/1ps
module scan_tick_gen
  import scan_mux_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  // Wrap is combinational on the last count; reset suppresses the pulse.
  assign wrap = en && (cnt_q == LAST);
  assign tick = wrap && !reset;

  // Next count: wrap to zero, advance when enabled, otherwise freeze.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_scan_mux.sv
// N-channel, W-bit registered multiplexer with manual select and
// automatic round-robin scan (e.g. for multiplexed seven-segment digits).
// Build option: define SCAN_ACTIVE_LOW_EN for active-low ch_en (all 1s idle).
`timescale 1ns/1ps
module param_scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 4,
  parameter int DIV  = 100000
) (
  input  logic               clk,
  input  logic               reset,
  param_scan_mux_if.slave    bus
);

  localparam int SELW = $clog2(N_CH);

`ifdef SCAN_ACTIVE_LOW_EN
  localparam logic [N_CH-1:0] CH_EN_IDLE = '1;
`else
  localparam logic [N_CH-1:0] CH_EN_IDLE = '0;
`endif

  scan_mode_e      mode;
  logic            scan_en;
  logic            pres_clr;
  logic            tick;

  logic [W-1:0]    chan [N_CH];

  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ch_d;
  logic [W-1:0]    y_q;
  logic [W-1:0]    y_d;
  logic [N_CH-1:0] ch_en_q;
  logic [N_CH-1:0] ch_en_d;
  logic [ONEHOT_MAXW-1:0] oh_full;

  assign mode = scan_mode_e'(bus.mode);

  // Prescaler runs only in auto mode without hold; manual mode keeps it
  // parked at zero so a switch to auto always starts a fresh slot.
  assign scan_en  = (mode == MODE_AUTO) && !bus.hold;
  assign pres_clr = reset || (mode == MODE_MANUAL);

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (pres_clr),
    .en    (scan_en),
    .tick  (tick)
  );

  // Unpack the channel bus into an indexable array.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign chan[gi] = bus.d[gi*W +: W];
  end

  // Channel select: follow sel in manual mode (ignoring out-of-range
  // values), step round-robin on each prescaler tick in auto mode.
  always_comb begin
    ch_d = ch_q;
    if (mode == MODE_MANUAL) begin
      if (int'(bus.sel) < N_CH) begin
        ch_d = bus.sel;
      end
    end else if (tick) begin
      ch_d = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
    end
  end

  // Output stage inputs derived from the current channel register, so y and
  // ch_en both trail ch by one cycle and change together.
  always_comb begin
    y_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == SELW'(k)) begin
        y_d = chan[k];
      end
    end
    oh_full = onehot(32'(ch_q), N_CH);
`ifdef SCAN_ACTIVE_LOW_EN
    ch_en_d = ~oh_full[N_CH-1:0];
`else
    ch_en_d = oh_full[N_CH-1:0];
`endif
  end

  // Channel and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q    <= '0;
      y_q     <= '0;
      ch_en_q <= CH_EN_IDLE;
    end else begin
      ch_q    <= ch_d;
      y_q     <= y_d;
      ch_en_q <= ch_en_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.ch_en = ch_en_q;
  assign bus.tick  = tick;

endmodule

// File: tb/tb_param_scan_mux.sv
// Scoreboard bench for param_scan_mux: a 4-channel (DIV=3) and a
// 3-channel (DIV=2) instance share stimulus; a slot-level model predicts
// each cycle's outputs and a monitor compares them after every edge.
`timescale 1ns/1ps
module tb_param_scan_mux;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] ch;
    logic [3:0] ch_en;
    logic       tick;
  } exp_t;

  logic clk;
  logic reset;

  param_scan_mux_if #(.N_CH(4), .W(4)) if4 ();
  param_scan_mux_if #(.N_CH(3), .W(4)) if3 ();

  param_scan_mux #(.N_CH(4), .W(4), .DIV(3)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  param_scan_mux #(.N_CH(3), .W(4), .DIV(2)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   m_cnt[2];
  int   m_ch[2];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a slot counter that wraps at DIV and a channel index that
  // wraps at N; outputs show the channel that was current before the edge.
  task automatic model_step(input int k, input bit rst, input bit md, input bit hd,
                            input int sl, input logic [15:0] dv, output exp_t e);
    int n;
    int dvv;
    int old;
    logic [3:0] oh;
    n   = (k == 0) ? 4 : 3;
    dvv = (k == 0) ? 3 : 2;
    e   = '0;
    oh  = 4'h0;
    if (rst) begin
      m_cnt[k] = 0;
      m_ch[k]  = 0;
    end else begin
      old  = m_ch[k];
      e.y  = 4'((dv >> (old * 4)) & 16'hF);
      oh   = 4'(1 << old);
      if (!md) begin
        m_cnt[k] = 0;
        if (sl < n) m_ch[k] = sl;
      end else if (!hd) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == dvv) begin
          m_cnt[k] = 0;
          m_ch[k]  = (m_ch[k] + 1) % n;
        end
      end
      e.tick = md && !hd && (m_cnt[k] == dvv - 1);
    end
`ifdef SCAN_ACTIVE_LOW_EN
    oh = ~oh;
`endif
    if (n == 3) oh[3] = 1'b0;
    e.ch_en = oh;
    e.ch    = 2'(m_ch[k]);
  endtask

  // Apply one cycle of inputs at the falling edge and queue the prediction.
  task automatic drive(input bit rst, input bit md, input bit hd,
                       input logic [1:0] sl, input logic [15:0] dv);
    exp_t e0;
    exp_t e1;
    @(negedge clk);
    reset    = rst;
    if4.mode = md;
    if3.mode = md;
    if4.hold = hd;
    if3.hold = hd;
    if4.sel  = sl;
    if3.sel  = sl;
    if4.d    = dv;
    if3.d    = dv[11:0];
    model_step(0, rst, md, hd, int'(sl), dv, e0);
    q0.push_back(e0);
    model_step(1, rst, md, hd, int'(sl), {4'h0, dv[11:0]}, e1);
    q1.push_back(e1);
  endtask

  task automatic check(input string name, input int k, input logic [3:0] act,
                       input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL dut%0d %s txn %0d: got %b expected %b", k, name, txn, act, req);
    end
  endtask

  // Monitor: after each rising edge compare the DUTs against queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        $display("txn %0d: dut4 y=%h ch=%0d ch_en=%b tick=%b", txn, if4.y, if4.ch,
                 if4.ch_en, if4.tick);
        check("y",     0, if4.y, e.y);
        check("ch",    0, {2'b00, if4.ch}, {2'b00, e.ch});
        check("ch_en", 0, if4.ch_en, e.ch_en);
        check("tick",  0, {3'b000, if4.tick}, {3'b000, e.tick});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("y",     1, if3.y, e.y);
        check("ch",    1, {2'b00, if3.ch}, {2'b00, e.ch});
        check("ch_en", 1, {1'b0, if3.ch_en}, e.ch_en);
        check("tick",  1, {3'b000, if3.tick}, {3'b000, e.tick});
      end
      txn++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dcur;
    logic [15:0] dfix;
    bit rst, md, hd;
    logic [1:0] sl;
    dfix     = 16'hDCBA;
    reset    = 1'b1;
    if4.mode = 1'b0; if3.mode = 1'b0;
    if4.hold = 1'b0; if3.hold = 1'b0;
    if4.sel  = 2'd0; if3.sel  = 2'd0;
    if4.d    = dfix; if3.d    = dfix[11:0];

    // Reset, then auto scan through all channels.
    repeat (2)  drive(1'b1, 1'b1, 1'b0, 2'd0, dfix);
    repeat (15) drive(1'b0, 1'b1, 1'b0, 2'd0, dfix);
    // Manual select of channel 2; hold is ignored here.
    repeat (3)  drive(1'b0, 1'b0, 1'b0, 2'd2, dfix);
    repeat (3)  drive(1'b0, 1'b0, 1'b1, 2'd2, dfix);
    // Park on channel 1, then hold in auto mode and release.
    repeat (2)  drive(1'b0, 1'b0, 1'b0, 2'd1, dfix);
    repeat (10) drive(1'b0, 1'b1, 1'b1, 2'd1, dfix);
    repeat (6)  drive(1'b0, 1'b1, 1'b0, 2'd1, dfix);
    // Out-of-range select on the 3-channel instance keeps channel 1.
    repeat (2)  drive(1'b0, 1'b0, 1'b0, 2'd1, dfix);
    repeat (3)  drive(1'b0, 1'b0, 1'b0, 2'd3, dfix);
    // Reset in the middle of a scan, then restart.
    repeat (7)  drive(1'b0, 1'b1, 1'b0, 2'd0, dfix);
    repeat (2)  drive(1'b1, 1'b1, 1'b0, 2'd0, dfix);
    repeat (4)  drive(1'b0, 1'b1, 1'b0, 2'd0, dfix);

    // Randomised traffic, including data changes on a stable channel.
    dcur = dfix;
    repeat (300) begin
      rst = ($urandom_range(0, 39) == 0);
      md  = ($urandom_range(0, 3) != 0);
      hd  = ($urandom_range(0, 4) == 0);
      sl  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) dcur = 16'($urandom);
      drive(rst, md, hd, sl, dcur);
    end

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d predictions left, expected 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_scan_mux.md
Name: param_scan_mux

Overview:
Parametrised N-channel, W-bit registered multiplexer with manual and automatic round-robin selection modes. In auto mode a built-in prescaler steps through the channels, which time-multiplexes a shared output such as Basys3 seven-segment digits. It also produces a one-hot channel enable that stays aligned with the data output. It is the general successor of the fixed 4:1 single-bit combinational mux.

Parameters:
N_CH, 4, number of input channels (>=2)
W, 4, bits per channel
DIV, 100000, clock cycles per auto-scan slot (>=1)
SELW, $clog2(N_CH), select/channel index width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
d  input  N_CH*W  packed channel data; channel k occupies d[k*W +: W]
mode  input  1  0 = manual (sel drives channel), 1 = auto scan
sel  input  SELW  manual channel select
hold  input  1  auto mode only: freeze prescaler and channel
y  output  W  registered selected data
ch  output  SELW  current channel register
ch_en  output  N_CH  registered one-hot enable, aligned with y
tick  output  1  single-cycle pulse when the prescaler wraps (auto mode only)

Behaviour:
- Reset values: cnt=0, ch=0, y=0, ch_en=all 0 (all 1 with SCAN_ACTIVE_LOW_EN), tick=0. Reset has priority over every other input. Asserting reset mid-scan clears all state on the next edge.
- Prescaler cnt counts 0..DIV-1 while mode=1 and hold=0. tick=1 combinationally when cnt==DIV-1 under the same conditions. At that edge cnt returns to 0.
- DIV=1 means tick is high on every enabled cycle.
- Auto mode: on a tick edge ch <= (ch==N_CH-1) ? 0 : ch+1.
- Hold: hold=1 in auto mode freezes both cnt and ch, and forces tick=0.
- Manual mode: ch <= sel each cycle (1-cycle latency). If sel>=N_CH (only possible when N_CH is not a power of 2), ch keeps its value. In manual mode cnt is held at 0 and tick=0.
- Mode switch manual->auto: cnt starts from 0, and scanning continues from the current ch.
- Mode switch auto->manual: ch loads sel on the next edge.
- Output stage: y <= d[ch*W +: W] and ch_en <= one-hot(ch). Both lag ch by exactly 1 cycle and always update together.
- The first edge after reset deasserts gives y=d[0] and ch_en=...0001.
- d changing on a stable channel appears on y after 1 cycle.
- The hold input is ignored in manual mode.

Optional Feature:
SCAN_ACTIVE_LOW_EN:
- Defined: ch_en is inverted (active-low, for the Basys3 anodes) and resets to all 1s.
- Undefined: ch_en is active-high and resets to all 0s.
- y, ch and tick are unaffected either way.

Decomposition:
- Package scan_mux_pkg holds:
  - the mode encoding typedef (enum logic {MODE_MANUAL=0, MODE_AUTO=1}),
  - a function onehot(idx, n),
  - a function clog2_min1 (ensures counter width >=1 when DIV=1).
- One sub-module: scan_tick_gen (prescaler). Parameter DIV; ports clk, reset, en, tick; en = mode & ~hold.

Test Plan:
All scenarios use N_CH=4, W=4, DIV=3 unless noted, with d = {4'hD,4'hC,4'hB,4'hA} (ch3..ch0).
1. Assert reset for 2 cycles -> y=0, ch=0, ch_en=0000, tick=0. On the first cycle after release (mode=1): y=A, ch_en=0001.
2. mode=1, hold=0 for 15 cycles -> tick every 3rd cycle. ch sequence 0,1,2,3,0 with each value lasting 3 cycles. y follows A,B,C,D,A one cycle behind ch. ch_en follows 0001,0010,0100,1000,0001.
3. mode=0, sel=2 -> ch=2 on the next edge; one edge later y=C and ch_en=0100; tick stays 0.
4. Auto mode with ch=1, hold=1 for 10 cycles -> ch=1, y=B, tick=0 throughout. Release hold -> the first tick arrives exactly 3 enabled cycles later and ch=2.
5. N_CH=3, manual sel=1 then sel=3 -> ch=1, then remains 1. y=B with no X and no out-of-range access.
6. Reset asserted while ch=2 in auto mode -> after the next edge all outputs hold their reset values. With SCAN_ACTIVE_LOW_EN defined, ch_en=1111 during reset and 1110 on the first cycle after release.
